// File: rtl/gmii_loopback_phy.sv
// gmii_loopback_phy: PHY-side GMII loopback emulator.
// Captures complete MAC TX frames into a byte buffer and validates the
// preamble/SFD, TX error and length. Only good frames are committed. Each
// committed frame is replayed verbatim on GMII RX, with at least IFG idle
// cycles between frames.
// Optional build macro: GMII_LOOPBACK_CRC_EN adds an FCS (CRC-32 residue)
// check to the frame-good condition.
module gmii_loopback_phy #(
  parameter int BUF_DEPTH = 4096,
  parameter int IFG       = 12
) (
  input  logic        clock125,
  input  logic        reset_n,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic [7:0]  gmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_er,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad,
  output logic        overflow
);

  localparam int AW = $clog2(BUF_DEPTH);
  typedef logic [AW-1:0] ptr_t;

  typedef enum logic [1:0] {C_WAIT_IDLE, C_IDLE, C_CAPTURE, C_DROP} cap_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rep_state_t;

  // {last, data} per entry
  logic [8:0] mem [BUF_DEPTH];

  ptr_t       wr, cm, rd;
  cap_state_t cap_st, cap_nxt;
  rep_state_t rep_st, rep_nxt;

  // Frame bookkeeping: byte index (saturating) and validity so far
  logic [3:0] cnt, idx;
  logic       frm_ok, frm_ok_cur, byte_bad, crc_good, frame_good, full;

  // The newest byte is held back one cycle so that the last flag can be
  // written together with it once the end of the frame is seen.
  logic       pend_vld;
  logic [7:0] pend_data;
  ptr_t       pend_addr;

  logic       take, commit, rollback, inc_ok, inc_bad, set_ovf;
  logic       mem_we;
  logic [8:0] mem_wd;

  logic       fetch, out_en;
  logic [8:0] rq;
  logic [7:0] gap_cnt;

  assign gmii_rx_er = 1'b0;

  assign full       = ptr_t'(wr + 1'b1) == rd;
  assign idx        = (cap_st == C_IDLE) ? 4'd0 : cnt;
  assign frm_ok_cur = (cap_st == C_IDLE) | frm_ok;
  assign byte_bad   = gmii_tx_er
                    | ((idx < 4'd7) && (gmii_txd != 8'h55))
                    | ((idx == 4'd7) && (gmii_txd != 8'hD5));
  assign frame_good = frm_ok && (cnt >= 4'd9) && crc_good;

`ifdef GMII_LOOPBACK_CRC_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running CRC over bytes after the SFD; held at the init value through the preamble
  always_ff @(posedge clock125 or negedge reset_n) begin
    if (!reset_n)            crc <= '1;
    else if (take) begin
      if (idx < 4'd8)        crc <= '1;
      else                   crc <= crc_step(crc, gmii_txd);
    end
  end

  assign crc_good = (crc == 32'hDEBB20E3);
`else
  assign crc_good = 1'b1;
`endif

  // Capture next-state and control decode
  always_comb begin
    cap_nxt  = cap_st;
    take     = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    inc_ok   = 1'b0;
    inc_bad  = 1'b0;
    set_ovf  = 1'b0;
    case (cap_st)
      C_WAIT_IDLE: if (!gmii_tx_en) cap_nxt = C_IDLE;
      C_IDLE: if (gmii_tx_en) begin
        if (full) begin cap_nxt = C_DROP; set_ovf = 1'b1; end
        else      begin cap_nxt = C_CAPTURE; take = 1'b1; end
      end
      C_CAPTURE: begin
        if (gmii_tx_en) begin
          if (full) begin cap_nxt = C_DROP; set_ovf = 1'b1; end
          else      take = 1'b1;
        end else begin
          cap_nxt = C_IDLE;
          if (frame_good) begin commit = 1'b1; inc_ok = 1'b1; end
          else            begin rollback = 1'b1; inc_bad = 1'b1; end
        end
      end
      C_DROP: if (!gmii_tx_en) begin
        cap_nxt  = C_IDLE;
        rollback = 1'b1;
        inc_bad  = 1'b1;
      end
      default: cap_nxt = C_WAIT_IDLE;
    endcase
  end

  // Pending byte goes to the buffer when its successor arrives or the frame commits
  assign mem_we = pend_vld & (take | commit);
  assign mem_wd = {commit, pend_data};

  // Capture state, pointers, pending byte and status counters
  always_ff @(posedge clock125 or negedge reset_n) begin
    if (!reset_n) begin
      cap_st     <= C_WAIT_IDLE;
      wr         <= '0;
      cm         <= '0;
      cnt        <= '0;
      frm_ok     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      pend_addr  <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
      overflow   <= 1'b0;
    end else begin
      cap_st <= cap_nxt;
      if (take) begin
        wr        <= wr + 1'b1;
        pend_vld  <= 1'b1;
        pend_data <= gmii_txd;
        pend_addr <= wr;
        frm_ok    <= frm_ok_cur & ~byte_bad;
        if (idx != 4'hF) cnt <= idx + 4'd1;
      end
      if (commit)   cm <= wr;
      if (rollback) wr <= cm;
      if (commit | rollback | set_ovf) pend_vld <= 1'b0;
      if (set_ovf) overflow <= 1'b1;
      if (inc_ok  && frames_ok  != 16'hFFFF) frames_ok  <= frames_ok  + 16'd1;
      if (inc_bad && frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
    end
  end

  // Buffer write port
  always_ff @(posedge clock125) begin
    if (mem_we) mem[pend_addr] <= mem_wd;
  end

  // Buffer read port: one entry ahead of the RX output register
  always_ff @(posedge clock125) begin
    if (fetch) rq <= mem[rd];
  end

  // Replay next-state: fetch while sending, stop after the last-flagged byte
  always_comb begin
    rep_nxt = rep_st;
    fetch   = 1'b0;
    out_en  = 1'b0;
    case (rep_st)
      R_IDLE: if (rd != cm) begin fetch = 1'b1; rep_nxt = R_SEND; end
      R_SEND: begin
        out_en = 1'b1;
        if (rq[8]) rep_nxt = R_GAP;
        else       fetch   = 1'b1;
      end
      R_GAP: if (gap_cnt == 8'(IFG - 1)) begin
        // Fetching on the final gap cycle keeps the gap at exactly IFG
        if (rd != cm) begin fetch = 1'b1; rep_nxt = R_SEND; end
        else          rep_nxt = R_IDLE;
      end
      default: rep_nxt = R_IDLE;
    endcase
  end

  // Replay state, read pointer, gap counter and RX output registers
  always_ff @(posedge clock125 or negedge reset_n) begin
    if (!reset_n) begin
      rep_st     <= R_IDLE;
      rd         <= '0;
      gap_cnt    <= '0;
      gmii_rxd   <= '0;
      gmii_rx_dv <= 1'b0;
    end else begin
      rep_st     <= rep_nxt;
      if (fetch) rd <= rd + 1'b1;
      gap_cnt    <= (rep_st == R_GAP) ? gap_cnt + 8'd1 : 8'd0;
      gmii_rx_dv <= out_en;
      gmii_rxd   <= out_en ? rq[7:0] : 8'h00;
    end
  end

endmodule

// File: tb/tb_gmii_loopback_phy.sv
// Scoreboard bench for gmii_loopback_phy: frames expected to replay are
// queued when driven and popped by the RX monitor.
module tb_gmii_loopback_phy;
  localparam int BD  = 128;
  localparam int GAP = 20;
`ifdef GMII_LOOPBACK_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clock125 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  gmii_txd = 8'h00;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_er = 1'b0;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [15:0] frames_ok, frames_bad;
  logic        overflow;

  int n_chk = 0, n_fail = 0;
  int exp_ok = 0, exp_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frm[$];
  int gap_q[$];
  int idle_run = 0;
  bit had_frame = 1'b0, prev_dv = 1'b0;

  always #4 clock125 = ~clock125;

  gmii_loopback_phy #(.BUF_DEPTH(BD), .IFG(GAP)) dut (
    .clock125(clock125), .reset_n(reset_n),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .frames_ok(frames_ok), .frames_bad(frames_bad), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RX monitor: compare each replayed byte, record idle gaps between frames
  always @(negedge clock125) begin
    if (!reset_n) begin
      prev_dv <= 1'b0; had_frame <= 1'b0; idle_run <= 0;
    end else if (gmii_rx_dv) begin
      if (!prev_dv && had_frame) gap_q.push_back(idle_run);
      if (exp_q.size() == 0) chk("rx_unexpected_byte", 1, 0);
      else                   chk("rx_byte", gmii_rxd, exp_q.pop_front());
      chk("rx_er", gmii_rx_er, 0);
      prev_dv <= 1'b1; had_frame <= 1'b1; idle_run <= 0;
    end else begin
      prev_dv <= 1'b0; idle_run <= idle_run + 1;
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Preamble, SFD, n random payload bytes, FCS (LSB first)
  task automatic build_frame(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    c = '1;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock125); #1; end
  endtask

  // Drive frm; tx_er asserted on byte err_at (-1: never). Returns just after
  // the edge that samples tx_en=0.
  task automatic send(input string tag, input int err_at, input bit good);
    if (good) begin
      foreach (frm[i]) exp_q.push_back(frm[i]);
      exp_ok++;
    end else exp_bad++;
    foreach (frm[i]) begin
      gmii_tx_en = 1'b1; gmii_txd = frm[i]; gmii_tx_er = (i == err_at);
      tick(1);
    end
    gmii_tx_en = 1'b0; gmii_tx_er = 1'b0; gmii_txd = 8'h00;
    tick(1);
    chk({tag, "_frames_ok"},  frames_ok,  exp_ok);
    chk({tag, "_frames_bad"}, frames_bad, exp_bad);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || gmii_rx_dv) && t < 3000) begin tick(1); t++; end
    chk({tag, "_drain_timeout"}, (t < 3000), 1);
    tick(GAP + 10);
    chk({tag, "_left_in_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    tick(3);
    chk("rst_rxd", gmii_rxd, 0);
    chk("rst_rx_dv", gmii_rx_dv, 0);
    chk("rst_rx_er", gmii_rx_er, 0);
    chk("rst_frames_ok", frames_ok, 0);
    chk("rst_frames_bad", frames_bad, 0);
    chk("rst_overflow", overflow, 0);

    // Frame already in flight at reset release is never captured
    build_frame(60);
    foreach (frm[i]) begin
      if (i == 10) reset_n = 1'b1;
      gmii_tx_en = 1'b1; gmii_txd = frm[i];
      tick(1);
    end
    gmii_tx_en = 1'b0;
    tick(5);
    chk("inflight_frames_ok", frames_ok, 0);
    chk("inflight_frames_bad", frames_bad, 0);
    drain("inflight");

    // 72-byte good frame with latency check
    build_frame(60);
    send("good72", -1, 1'b1);
    chk("lat_edge0", gmii_rx_dv, 0);
    tick(1);
    chk("lat_edge1", gmii_rx_dv, 0);
    tick(1);
    chk("lat_edge2", gmii_rx_dv, 1);
    drain("good72");

    // tx_er inside frame
    build_frame(60);
    send("txer20", 20, 1'b0);
    drain("txer20");

    // Bad SFD
    build_frame(60);
    frm[7] = 8'h55;
    send("bad_sfd", -1, 1'b0);
    drain("bad_sfd");

    // tx_er while tx_en=0 is ignored; next frame also proves rollback
    gmii_tx_er = 1'b1; gmii_txd = 8'hD5; tick(3);
    gmii_tx_er = 1'b0; tick(2);
    build_frame(60);
    send("idle_txer", -1, 1'b1);
    drain("idle_txer");

    // Length boundary: 8 bytes rejected, 9 bytes accepted (no valid FCS)
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    send("len8", -1, 1'b0);
    drain("len8");
    frm.push_back(8'hA7);
    send("len9", -1, !CRC_ON);
    drain("len9");

    // Overflow: frame larger than capacity, then a good 40-byte frame
    build_frame(148);
    send("ovf160", -1, 1'b0);
    chk("ovf_flag", overflow, 1);
    drain("ovf160");
    build_frame(28);
    send("after_ovf40", -1, 1'b1);
    drain("after_ovf40");
    chk("ovf_sticky", overflow, 1);

    // Three back-to-back frames, 12-cycle MAC gap
    gap_q.delete();
    for (int k = 0; k < 3; k++) begin
      build_frame(60);
      send("b2b", -1, 1'b1);
      if (k < 2) tick(11);
    end
    drain("b2b");
    chk("b2b_gap_count", gap_q.size(), 3);
    if (gap_q.size() >= 3) begin
      chk("b2b_gap1", gap_q[1], GAP);
      chk("b2b_gap2", gap_q[2], GAP);
    end

    // Corrupted FCS bit
    build_frame(60);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    send("bad_fcs", -1, !CRC_ON);
    drain("bad_fcs");

    // Reset during replay: rx_dv drops without waiting for a clock edge
    build_frame(60);
    send("mid_rst", -1, 1'b1);
    tick(6);
    chk("mid_rst_dv_before", gmii_rx_dv, 1);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_dv_async", gmii_rx_dv, 0);
    exp_q.delete();
    exp_ok = 0; exp_bad = 0;
    tick(2);
    chk("mid_rst_frames_ok", frames_ok, 0);
    chk("mid_rst_frames_bad", frames_bad, 0);
    chk("mid_rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick(30);
    chk("post_rst_no_replay", gmii_rx_dv, 0);
    build_frame(60);
    send("post_rst", -1, 1'b1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1);
  end

endmodule
